// File: rtl/key_pattern_receiver_pkg.sv
// Shared types and constants for the push-button pattern receiver.
package key_pattern_receiver_pkg;

  localparam int DEFAULT_N_BITS = 16;

  localparam logic BIT_FROM_KEY0 = 1'b0;
  localparam logic BIT_FROM_KEY1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/key_pattern_receiver_if.sv
// Bit stream and pattern valid/ready bus between the receiver and the weight update logic.
interface key_pattern_receiver_if
  import key_pattern_receiver_pkg::*;
#(
  parameter int N_BITS = DEFAULT_N_BITS
);
  localparam int CW = $clog2(N_BITS) + 1;

  logic              bit_valid;
  logic              bit_value;
  logic [CW-1:0]     bit_count;
  logic [N_BITS-1:0] pattern;
  logic              pattern_valid;
  logic              pattern_ready;

  modport master (
    output bit_valid, bit_value, bit_count, pattern, pattern_valid,
    input  pattern_ready
  );

  modport slave (
    input  bit_valid, bit_value, bit_count, pattern, pattern_valid,
    output pattern_ready
  );

endinterface

// File: rtl/key_pattern_receiver_debounce.sv
// Two-flop synchroniser for one raw key plus a counter of consecutive samples at the expected level.
module key_pattern_receiver_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  input  logic expect_i,
  input  logic clear_i,
  output logic ks_o,
  output logic done_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             match;

  // Synchronisers preset to the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      meta_q <= key_i;
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
    end
  end

  assign match = (sync_q == expect_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !match) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign ks_o   = sync_q;
  assign done_o = match && (cnt_q == LAST);

endmodule

// File: rtl/key_pattern_receiver.sv
// Push-button pattern receiver: debounces key0/key1, handshakes each press through busy,
// and assembles N_BITS presses into a word offered on a valid/ready bus.
module key_pattern_receiver
  import key_pattern_receiver_pkg::*;
#(
  parameter int N_BITS          = DEFAULT_N_BITS,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic CLOCK_50,
  input  logic rst,
  input  logic key0,
  input  logic key1,
  output logic busy,
  output logic dropped,
  key_pattern_receiver_if.master pat
);

  localparam int CW = $clog2(N_BITS) + 1;
  localparam int IW = CW - 1;

  rx_state_e         state_q, state_d;
  logic              cand_q, cand_d;
  logic              lockout_q, lockout_d;
  logic              busy_q, busy_d;
  logic              bit_valid_q, bit_valid_d;
  logic              bit_value_q, bit_value_d;
  logic [CW-1:0]     bit_count_q, bit_count_d;
  logic [N_BITS-1:0] pattern_q, pattern_d;
  logic              pvalid_q, pvalid_d;
  logic              dropped_q, dropped_d;

  logic k0s, k1s;
  logic done0, done1;
  logic exp0, exp1;
  logic clear_db;
  logic press_good;
  logic accept;
  logic release_done;

  key_pattern_receiver_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db0 (
    .clk     (CLOCK_50),
    .rst     (rst),
    .key_i   (key0),
    .expect_i(exp0),
    .clear_i (clear_db),
    .ks_o    (k0s),
    .done_o  (done0)
  );

  key_pattern_receiver_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db1 (
    .clk     (CLOCK_50),
    .rst     (rst),
    .key_i   (key1),
    .expect_i(exp1),
    .clear_i (clear_db),
    .ks_o    (k1s),
    .done_o  (done1)
  );

  // Only the candidate key is expected low during press debounce; everywhere else both idle high.
  assign exp0       = !((state_q == PRESS_DB) && (cand_q == BIT_FROM_KEY0));
  assign exp1       = !((state_q == PRESS_DB) && (cand_q == BIT_FROM_KEY1));
  assign press_good = (cand_q == BIT_FROM_KEY0) ? (!k0s && k1s) : (k0s && !k1s);

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_q      <= BIT_FROM_KEY0;
      lockout_q   <= 1'b1;
      busy_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_value_q <= 1'b0;
      bit_count_q <= '0;
      pattern_q   <= '0;
      pvalid_q    <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      lockout_q   <= lockout_d;
      busy_q      <= busy_d;
      bit_valid_q <= bit_valid_d;
      bit_value_q <= bit_value_d;
      bit_count_q <= bit_count_d;
      pattern_q   <= pattern_d;
      pvalid_q    <= pvalid_d;
      dropped_q   <= dropped_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    case (state_q)
      IDLE: begin
        if (!lockout_q && (k0s != k1s)) begin
          state_d = PRESS_DB;
          cand_d  = k0s ? BIT_FROM_KEY1 : BIT_FROM_KEY0;
        end
      end
      PRESS_DB: begin
        if (!press_good) begin
          state_d = IDLE;
        end else if (done0 && done1) begin
          state_d = HELD;
        end
      end
      HELD: begin
        if (k0s && k1s) begin
          state_d = REL_DB;
        end
      end
      REL_DB: begin
        if (!(k0s && k1s)) begin
          state_d = HELD;
        end else if (done0 && done1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clear_db = ((state_q == IDLE) && (state_d == PRESS_DB)) ||
                    ((state_q == HELD) && (state_d == REL_DB));

  // Lockout holds off new presses after reset or a two-key press until both keys are stably released.
  always_comb begin
    accept       = (state_q == PRESS_DB) && press_good && done0 && done1;
    release_done = (state_q == REL_DB) && k0s && k1s && done0 && done1;

    lockout_d = lockout_q;
    if (state_q == IDLE) begin
      if (!k0s && !k1s) begin
        lockout_d = 1'b1;
      end else if (done0 && done1) begin
        lockout_d = 1'b0;
      end
    end

    busy_d      = busy_q;
    bit_valid_d = 1'b0;
    dropped_d   = 1'b0;
    bit_value_d = bit_value_q;
    bit_count_d = bit_count_q;
    pattern_d   = pattern_q;
    pvalid_d    = pvalid_q;

    if (accept) begin
      busy_d = 1'b1;
      if (!pvalid_q) begin
        pattern_d[bit_count_q[IW-1:0]] = cand_q;
        bit_value_d = cand_q;
        bit_valid_d = 1'b1;
        bit_count_d = bit_count_q + CW'(1);
        if (bit_count_q == CW'(N_BITS - 1)) begin
          pvalid_d = 1'b1;
        end
      end else begin
        dropped_d = 1'b1;
      end
    end

    if (release_done) begin
      busy_d = 1'b0;
    end

    if (pvalid_q && pat.pattern_ready) begin
      pvalid_d    = 1'b0;
      bit_count_d = '0;
    end
  end

  assign busy              = busy_q;
  assign dropped           = dropped_q;
  assign pat.bit_valid     = bit_valid_q;
  assign pat.bit_value     = bit_value_q;
  assign pat.bit_count     = bit_count_q;
  assign pat.pattern       = pattern_q;
  assign pat.pattern_valid = pvalid_q;

endmodule

// File: tb/tb_key_pattern_receiver.sv
// Bench for key_pattern_receiver: directed protocol scenarios followed by randomized
// presses, glitches and handshakes, checked against a queue-based model of the press rules.
module tb_key_pattern_receiver;
  import key_pattern_receiver_pkg::*;

  localparam int N_BITS = 16;
  localparam int DB     = 4;
  localparam int LAT    = 2 + DB + 1;

  logic clock = 1'b0;
  logic rst;
  logic key0;
  logic key1;
  logic busy;
  logic dropped;

  int checkCount  = 0;
  int errorCount  = 0;
  int bitPulses   = 0;
  int dropPulses  = 0;
  int modelStores = 0;
  int modelDrops  = 0;

  bit                modelQ[$];
  logic [N_BITS-1:0] heldWord = '0;
  logic [N_BITS-1:0] snap;
  logic              busySeen;
  bit                fullSeq[16] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0};

  key_pattern_receiver_if #(.N_BITS(N_BITS)) pat ();

  key_pattern_receiver #(
    .N_BITS         (N_BITS),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (20)
  ) dut (
    .CLOCK_50(clock),
    .rst     (rst),
    .key0    (key0),
    .key1    (key1),
    .busy    (busy),
    .dropped (dropped),
    .pat     (pat)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rst == 1'b0) begin
      if (pat.bit_valid) bitPulses++;
      if (dropped) dropPulses++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic k0, input logic k1);
    key0 = k0;
    key1 = k1;
  endtask

  function automatic logic [N_BITS-1:0] expectedWord();
    logic [N_BITS-1:0] w;
    w = heldWord;
    foreach (modelQ[i]) w[i] = modelQ[i];
    return w;
  endfunction

  task automatic checkState();
    checkOutput("bit_count", pat.bit_count, modelQ.size());
    checkOutput("pattern_valid", pat.pattern_valid, modelQ.size() == N_BITS);
    checkOutput("pattern", pat.pattern, expectedWord());
    checkOutput("bit_valid pulses", bitPulses, modelStores);
    checkOutput("dropped pulses", dropPulses, modelDrops);
  endtask

  task automatic pressKey(input bit value, input int hold);
    bit stores;
    stores = (modelQ.size() < N_BITS);
    if (value == BIT_FROM_KEY1) applyStimulus(1'b1, 1'b0);
    else applyStimulus(1'b0, 1'b1);
    waitCycles(LAT - 1);
    checkOutput("busy before accept", busy, 1'b0);
    waitCycles(1);
    checkOutput("busy at accept", busy, 1'b1);
    checkOutput("bit_valid at accept", pat.bit_valid, stores);
    checkOutput("dropped at accept", dropped, !stores);
    if (stores) begin
      checkOutput("bit_value", pat.bit_value, value);
      modelQ.push_back(value);
      modelStores++;
    end else begin
      modelDrops++;
    end
    waitCycles(1);
    checkOutput("bit_valid width", pat.bit_valid, 1'b0);
    checkOutput("dropped width", dropped, 1'b0);
    checkState();
    waitCycles(hold);
  endtask

  task automatic releaseKey(input int gap);
    applyStimulus(1'b1, 1'b1);
    waitCycles(LAT - 1);
    checkOutput("busy before release confirm", busy, 1'b1);
    waitCycles(1);
    checkOutput("busy after release", busy, 1'b0);
    waitCycles(gap);
  endtask

  task automatic pressRelease(input bit value, input int hold, input int gap);
    pressKey(value, hold);
    releaseKey(gap);
  endtask

  task automatic doHandshake();
    pat.pattern_ready = 1'b1;
    waitCycles(1);
    pat.pattern_ready = 1'b0;
    if (modelQ.size() == N_BITS) begin
      heldWord = expectedWord();
      modelQ.delete();
    end
    checkState();
  endtask

  task automatic glitchKey(input bit which, input int len);
    logic seen;
    seen = 1'b0;
    if (which) applyStimulus(1'b1, 1'b0);
    else applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < len; i++) begin
      waitCycles(1);
      seen |= busy;
    end
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      waitCycles(1);
      seen |= busy;
    end
    checkOutput("glitch busy", seen, 1'b0);
    checkState();
  endtask

  task automatic doReset();
    rst = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    modelQ.delete();
    heldWord = '0;
    waitCycles(10);
  endtask

  initial begin
    int r;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1);
    pat.pattern_ready = 1'b0;
    waitCycles(3);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset bit_valid", pat.bit_valid, 1'b0);
    checkOutput("reset bit_value", pat.bit_value, 1'b0);
    checkOutput("reset bit_count", pat.bit_count, 0);
    checkOutput("reset pattern", pat.pattern, 0);
    checkOutput("reset pattern_valid", pat.pattern_valid, 1'b0);
    checkOutput("reset dropped", dropped, 1'b0);
    rst = 1'b0;
    waitCycles(10);

    $display("[TB] reset during press debounce");
    applyStimulus(1'b1, 1'b0);
    waitCycles(3);
    rst = 1'b1;
    #1;
    checkOutput("busy in async reset", busy, 1'b0);
    checkOutput("bit_count in async reset", pat.bit_count, 0);
    waitCycles(2);
    rst = 1'b0;
    modelQ.delete();
    heldWord = '0;
    busySeen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      waitCycles(1);
      busySeen |= busy;
    end
    checkOutput("busy with key held over reset", busySeen, 1'b0);
    checkState();
    applyStimulus(1'b1, 1'b1);
    waitCycles(10);
    pressRelease(1'b1, 2, 3);

    $display("[TB] glitch rejection");
    glitchKey(1'b0, 2);
    doReset();

    $display("[TB] full press sequence");
    foreach (fullSeq[i]) pressRelease(fullSeq[i], 1, 2);
    checkOutput("full pattern", pat.pattern, 16'h33E3);
    checkOutput("full bit_count", pat.bit_count, 16);
    checkOutput("full pattern_valid", pat.pattern_valid, 1'b1);

    $display("[TB] overflow and handshake");
    repeat (3) pressRelease(1'b1, 1, 2);
    checkOutput("pattern after drops", pat.pattern, 16'h33E3);
    doHandshake();
    checkOutput("valid after handshake", pat.pattern_valid, 1'b0);
    checkOutput("count after handshake", pat.bit_count, 0);
    pressRelease(1'b1, 1, 2);
    pressRelease(1'b1, 1, 2);
    pressRelease(1'b0, 1, 2);
    snap = pat.pattern;
    checkOutput("pattern low bits", snap[2:0], 3'b011);
    checkOutput("count after refill", pat.bit_count, 3);
    doHandshake();

    $display("[TB] both keys together");
    busySeen = 1'b0;
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      waitCycles(1);
      busySeen |= busy;
    end
    applyStimulus(1'b1, 1'b1);
    waitCycles(10);
    checkOutput("busy for two-key press", busySeen, 1'b0);
    checkState();

    $display("[TB] release bounce");
    pressKey(1'b0, 2);
    applyStimulus(1'b1, 1'b1);
    waitCycles(2);
    applyStimulus(1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("busy during bounce", busy, 1'b1);
    waitCycles(LAT - 1);
    checkOutput("busy before bounce release confirm", busy, 1'b1);
    waitCycles(1);
    checkOutput("busy after bounce release", busy, 1'b0);
    waitCycles(3);
    checkState();

    $display("[TB] randomized presses");
    for (int n = 0; n < 70; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        glitchKey($urandom_range(0, 1) == 1, int'($urandom_range(1, DB)));
      end else if (r == 2) begin
        doHandshake();
      end else begin
        pressRelease($urandom_range(0, 1) == 1, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
      end
    end
    checkState();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/key_pattern_receiver.md
Name: key_pattern_receiver

Overview:
- Responder side of the push-button protocol: the operator presses key0/key1 (active-low) once per bit, and the bench press-sequencer drives the same protocol.
- Synchronises and debounces both keys, and handshakes each press through a busy flag: busy rises on an accepted press and falls on a confirmed release.
- Assembles N_BITS presses into a pattern word and hands the word to the weight/neuron update logic over a valid/ready handshake.
- Sits between the top-level key pins and the weight module.

Parameters:
- N_BITS, 16, number of presses per pattern.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to confirm a press or a release. Use 4 in sim, 1000000 on board.
- CNT_W, 20, width of the debounce counter. Must hold DEBOUNCE_CYCLES.

Ports:
- CLOCK_50  in   1  system clock.
- rst  in  1  asynchronous reset, active-high.
- key0  in  1  raw button, active-low; a press means bit value 0.
- key1  in  1  raw button, active-low; a press means bit value 1.
- busy  out  1  1 from press acceptance until release confirmation.
- bit_valid  out  1  one-cycle pulse when a bit is stored.
- bit_value  out  1  value of the stored bit; valid with bit_valid.
- bit_count  out  $clog2(N_BITS)+1  number of bits stored so far.
- pattern  out  N_BITS  assembled word; bit i is the i-th press.
- pattern_valid  out  1  pattern complete.
- pattern_ready  in  1  consumer accepts the pattern.
- dropped  out  1  one-cycle pulse when a press is accepted while pattern_valid=1.

Behaviour:
- Reset (asynchronous, any state, any time):
  - busy=0, bit_valid=0, bit_value=0, bit_count=0, pattern=0, pattern_valid=0, dropped=0.
  - FSM goes to IDLE, debounce counter=0.
  - Synchronisers preset to 1 (released).
- Synchronisers: each key passes through 2 flops before use; k0s, k1s are the synchronised values.
- FSM states:
  - IDLE: if exactly one of k0s/k1s is 0, latch the candidate value (0 for key0, 1 for key1), clear the counter, go to PRESS_DB. If both are 0 or both are 1, stay in IDLE.
  - PRESS_DB: the counter increments each cycle while the candidate key stays 0 and the other key stays 1. Any deviation returns to IDLE with no bit stored. When counter = DEBOUNCE_CYCLES-1 and the sample is still good, accept the press and go to HELD.
  - HELD: wait until both k0s=1 and k1s=1, then clear the counter and go to REL_DB. Pressing the other key while in HELD is ignored.
  - REL_DB: requires DEBOUNCE_CYCLES consecutive cycles with both keys high, then go to IDLE. Any low sample returns to HELD.
- Accept cycle (registered outputs, visible the next edge):
  - busy <= 1.
  - If pattern_valid=0: pattern[bit_count] <= value, bit_value <= value, bit_valid pulses, bit_count increments.
  - If pattern_valid=1: dropped pulses and nothing else changes.
- busy falls in the cycle the FSM leaves REL_DB for IDLE.
- Latency, key fall to busy=1: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, i.e. 7 cycles at default.
- Full: when bit_count reaches N_BITS on a store, pattern_valid <= 1 in the same registered update.
- Handshake:
  - On pattern_valid && pattern_ready: pattern_valid <= 0 and bit_count <= 0. pattern holds its value until it is overwritten bit by bit.
  - pattern_ready while pattern_valid=0 has no effect.
  - pattern_valid stays high indefinitely until the handshake.
- Simultaneous accept and handshake cannot occur, because accept only stores when valid=0. A press accepted in the handshake cycle still sees valid=1 and is dropped.
- Both keys low at entry to IDLE: no bit. The keys must both be released before another press is recognised.

Decomposition:
- Shared package (balls_pkg), holding:
  - FSM state encoding: IDLE=0, PRESS_DB=1, HELD=2, REL_DB=3.
  - Default N_BITS.
  - BIT_FROM_KEY0=0 and BIT_FROM_KEY1=1 constants.
- Natural sub-module: key_debounce, containing the 2-flop synchroniser plus the stable-count comparator. Instantiate it once per key; the FSM combines the two outputs.

Test Plan:
- Reset mid-PRESS_DB:
  - Stimulus: key1 held low, rst pulsed after 3 cycles.
  - Response: busy=0, bit_count=0. No bit_valid until key1 is released and pressed again.
- Glitch rejection:
  - Stimulus: key0 low for 2 cycles, then high.
  - Response: no busy, no bit_valid, FSM back in IDLE.
- Full press sequence:
  - Stimulus: presses 1,1,0,0,0,1,1,1,1,1,0,0,1,1,0,0, each waiting busy=1 then release and busy=0, with pattern_ready=0.
  - Response: pattern=16'h33E3, bit_count=16, pattern_valid=1.
- Full overflow:
  - Stimulus: continuing the previous test, press key1 three times.
  - Response: 3 dropped pulses, pattern unchanged at 16'h33E3.
  - Stimulus: then assert pattern_ready for 1 cycle.
  - Response: pattern_valid=0, bit_count=0.
  - Stimulus: next presses 1,1,0.
  - Response: pattern[2:0]=3'b011, bit_count=3.
- Both keys together:
  - Stimulus: key0 and key1 low in the same cycle for 20 cycles, then released.
  - Response: no bit stored, busy stays 0.
- Release bounce:
  - Stimulus: in HELD, keys go high 2 cycles, low 1 cycle, then high.
  - Response: busy stays 1 until 4 stable high cycles after the final rise. Exactly one bit_valid for the whole press.
